// File: rtl/flag_branch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit_if
// Description : Flag-capture and branch-request bundle for flag_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface flag_branch_unit_if #(
   parameter int size     = 32,
   parameter int condSize = 3
);
   logic                flag_we;
   logic                carryflag;
   logic                signflag;
   logic                overflowflag;
   logic                zflag;
   logic                br_valid;
   logic [condSize-1:0] br_cond;
   logic [size-1:0]     br_target;
   logic [size-1:0]     pc_plus;
   logic                link_en;
   logic                taken;
   logic                flush;
   logic                busy;
   logic                link_we;
   logic [size-1:0]     redirect_pc;
   logic [size-1:0]     link_value;
   logic [3:0]          flags_q;

   modport master (
      output flag_we, carryflag, signflag, overflowflag, zflag,
      output br_valid, br_cond, br_target, pc_plus, link_en,
      input  taken, flush, busy, link_we, redirect_pc, link_value, flags_q
   );

   modport slave (
      input  flag_we, carryflag, signflag, overflowflag, zflag,
      input  br_valid, br_cond, br_target, pc_plus, link_en,
      output taken, flush, busy, link_we, redirect_pc, link_value, flags_q
   );
endinterface
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : flag_branch_unit
// Description : ALU flag register plus conditional branch redirect/flush FSM.
//               Optional macro FLAG_BYPASS_EN evaluates the condition on the
//               incoming ALU flags when they are written on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module flag_branch_unit #(
   parameter int size     = 32,
   parameter int condSize = 3
) (
   input  logic              clk,
   input  logic              rst,
   flag_branch_unit_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [3:0]      r_flags;
   logic [size-1:0] r_redirect_pc;
   logic [size-1:0] r_link_value;
   logic            r_link_pend;
   logic [3:0]      w_in_flags;
   logic [3:0]      w_eval_flags;
   logic            w_cond_true;
   logic            w_take;

   // Flag bit order: {carry, sign, overflow, zero}
   assign w_in_flags = {bus.carryflag, bus.signflag, bus.overflowflag, bus.zflag};

`ifdef FLAG_BYPASS_EN
   assign w_eval_flags = bus.flag_we ? w_in_flags : r_flags;
`else
   assign w_eval_flags = r_flags;
`endif

   always_comb begin
      w_cond_true = 1'b0;
      case (bus.br_cond)
         3'b000:  w_cond_true = 1'b1;
         3'b001:  w_cond_true = w_eval_flags[0];
         3'b010:  w_cond_true = ~w_eval_flags[0];
         3'b011:  w_cond_true = w_eval_flags[3];
         3'b100:  w_cond_true = ~w_eval_flags[3];
         3'b101:  w_cond_true = w_eval_flags[2];
         3'b110:  w_cond_true = ~w_eval_flags[2];
         3'b111:  w_cond_true = w_eval_flags[1];
         default: w_cond_true = 1'b0;
      endcase
   end

   always_comb begin
      w_next = r_state;
      w_take = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.br_valid && w_cond_true) begin
               w_take = 1'b1;
               w_next = REDIRECT;
            end
         end
         REDIRECT: w_next = FLUSH;
         FLUSH:    w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Flag writes from instructions being squashed (non-IDLE) are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flags       <= 4'd0;
         r_redirect_pc <= '0;
         r_link_value  <= '0;
         r_link_pend   <= 1'b0;
      end else begin
         if (r_state == IDLE && bus.flag_we) begin
            r_flags <= w_in_flags;
         end
         if (w_take) begin
            r_redirect_pc <= bus.br_target;
            r_link_pend   <= bus.link_en;
            if (bus.link_en) begin
               r_link_value <= bus.pc_plus;
            end
         end
      end
   end

   assign bus.taken       = (r_state == REDIRECT);
   assign bus.flush       = (r_state != IDLE);
   assign bus.busy        = (r_state != IDLE);
   assign bus.link_we     = (r_state == REDIRECT) && r_link_pend;
   assign bus.redirect_pc = r_redirect_pc;
   assign bus.link_value  = r_link_value;
   assign bus.flags_q     = r_flags;
endmodule
`default_nettype wire

// File: tb/tb_flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_flag_branch_unit
// Description : Table-driven directed bench for flag_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flag_branch_unit;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   flag_branch_unit_if #(.size(32), .condSize(3)) bus ();

   flag_branch_unit #(.size(32), .condSize(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        fwe;
      logic [3:0]  fl;
      logic        bv;
      logic [2:0]  cond;
      logic [31:0] tgt;
      logic [31:0] pcp;
      logic        len;
      logic        e_taken;
      logic        e_flush;
      logic        e_lwe;
      logic [3:0]  e_flags;
      logic [31:0] e_rpc;
      logic [31:0] e_lval;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic fwe, logic [3:0] fl, logic bv,
                               logic [2:0] cond, logic [31:0] tgt, logic [31:0] pcp,
                               logic len, logic et, logic ef, logic el,
                               logic [3:0] eflags, logic [31:0] erpc, logic [31:0] elval);
      vec_t v;
      v.rst = r; v.fwe = fwe; v.fl = fl; v.bv = bv; v.cond = cond;
      v.tgt = tgt; v.pcp = pcp; v.len = len;
      v.e_taken = et; v.e_flush = ef; v.e_lwe = el;
      v.e_flags = eflags; v.e_rpc = erpc; v.e_lval = elval;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst              = v.rst;
      bus.flag_we      = v.fwe;
      bus.carryflag    = v.fl[3];
      bus.signflag     = v.fl[2];
      bus.overflowflag = v.fl[1];
      bus.zflag        = v.fl[0];
      bus.br_valid     = v.bv;
      bus.br_cond      = v.cond;
      bus.br_target    = v.tgt;
      bus.pc_plus      = v.pcp;
      bus.link_en      = v.len;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, " taken"},       32'(bus.taken),   32'(v.e_taken));
      chk({tag, " flush"},       32'(bus.flush),   32'(v.e_flush));
      chk({tag, " busy"},        32'(bus.busy),    32'(v.e_flush));
      chk({tag, " link_we"},     32'(bus.link_we), 32'(v.e_lwe));
      chk({tag, " flags_q"},     32'(bus.flags_q), 32'(v.e_flags));
      chk({tag, " redirect_pc"}, bus.redirect_pc,  v.e_rpc);
      chk({tag, " link_value"},  bus.link_value,   v.e_lval);
   endtask

   task automatic step(input string tag, input vec_t v);
      drive(v);
      @(posedge clk);
      #1;
      check_vec(tag, v);
   endtask

   initial begin
      vec_t v;
      logic exp_byp;
      n_checks = 0;
      n_errors = 0;

      //          rst fwe fl     bv cond    tgt     pcp     len  t  f  lw flags    rpc     lval
      vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 1, 4'h1, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h1, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd1, 32'h40,  32'h44,  0, 1, 1, 0, 4'h1, 32'h40,  32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 1, 0, 4'h1, 32'h40,  32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h1, 32'h40,  32'h0));
      vecs.push_back(mk(0, 1, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h40,  32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd1, 32'h99,  32'h9c,  0, 0, 0, 0, 4'h0, 32'h40,  32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd2, 32'h60,  32'h64,  1, 1, 1, 1, 4'h0, 32'h60,  32'h64));
      // New branch and flag write while REDIRECT / FLUSH are both squashed
      vecs.push_back(mk(0, 1, 4'hF, 1, 3'd0, 32'h80,  32'h84,  1, 0, 1, 0, 4'h0, 32'h60,  32'h64));
      vecs.push_back(mk(0, 1, 4'hA, 1, 3'd0, 32'h88,  32'h8c,  1, 0, 0, 0, 4'h0, 32'h60,  32'h64));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd0, 32'h200, 32'h104, 1, 1, 1, 1, 4'h0, 32'h200, 32'h104));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 1, 0, 4'h0, 32'h200, 32'h104));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h200, 32'h104));
      vecs.push_back(mk(0, 1, 4'h8, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h8, 32'h200, 32'h104));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd3, 32'h300, 32'h304, 1, 1, 1, 1, 4'h8, 32'h300, 32'h304));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 1, 0, 4'h8, 32'h300, 32'h304));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h8, 32'h300, 32'h304));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd4, 32'h400, 32'h404, 1, 0, 0, 0, 4'h8, 32'h300, 32'h304));
      vecs.push_back(mk(0, 1, 4'h4, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h4, 32'h300, 32'h304));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd5, 32'h500, 32'h504, 0, 1, 1, 0, 4'h4, 32'h500, 32'h304));
      vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd6, 32'h600, 32'h604, 0, 1, 1, 0, 4'h0, 32'h600, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 1, 0, 4'h0, 32'h600, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h600, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd7, 32'h700, 32'h704, 0, 0, 0, 0, 4'h0, 32'h600, 32'h0));
      vecs.push_back(mk(0, 1, 4'h2, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h2, 32'h600, 32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 1, 3'd7, 32'h710, 32'h714, 1, 1, 1, 1, 4'h2, 32'h710, 32'h714));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 1, 0, 4'h2, 32'h710, 32'h714));
      // Reset during FLUSH, then reset overriding a branch and flag write
      vecs.push_back(mk(1, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h0,   32'h0));
      vecs.push_back(mk(1, 1, 4'hF, 1, 3'd0, 32'h900, 32'h904, 1, 0, 0, 0, 4'h0, 32'h0,   32'h0));
      vecs.push_back(mk(0, 0, 4'h0, 0, 3'd0, 32'h0,   32'h0,   0, 0, 0, 0, 4'h0, 32'h0,   32'h0));

      drive(mk(1, 0, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0));
      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         step($sformatf("v%0d", i), vecs[i]);
      end

      // Same-edge flag write and branch: outcome depends on the bypass build
`ifdef FLAG_BYPASS_EN
      exp_byp = 1'b1;
`else
      exp_byp = 1'b0;
`endif
      step("byp_rst", mk(1, 0, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0));
      step("byp_z0",  mk(0, 1, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 4'h0, 32'h0, 32'h0));
      v = mk(0, 1, 4'h1, 1, 3'd1, 32'h90, 32'h94, 1, exp_byp, exp_byp, exp_byp, 4'h1,
             exp_byp ? 32'h90 : 32'h0, exp_byp ? 32'h94 : 32'h0);
      step("byp_eval", v);
      v = mk(0, 0, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 0, exp_byp, 0, 4'h1,
             exp_byp ? 32'h90 : 32'h0, exp_byp ? 32'h94 : 32'h0);
      step("byp_next", v);
      v = mk(0, 0, 4'h0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 4'h1,
             exp_byp ? 32'h90 : 32'h0, exp_byp ? 32'h94 : 32'h0);
      step("byp_idle", v);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/flag_branch_unit.md
FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 Parameter: size, 32, address/data width of PC and link values.
REQ-002 Parameter: condSize, 3, width of branch condition code.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flag_we  input  1  capture ALU flags this cycle.
REQ-006 carryflag, signflag, overflowflag, zflag  input  1 each  flags from the ALU.
REQ-007 br_valid  input  1  branch instruction present this cycle.
REQ-008 br_cond  input  condSize  condition code, encoding per REQ-013.
REQ-009 br_target  input  size  branch destination address.
REQ-010 pc_plus  input  size  address of instruction following the branch.
REQ-011 link_en  input  1  branch is a call; return address written to link register.
REQ-012 taken, flush, busy, link_we  output  1 each; redirect_pc, link_value  output  size each; flags_q  output  4  registered {carry,sign,overflow,zero}.

Function
REQ-013 Conditions: 000 always; 001 z=1; 010 z=0; 011 c=1; 100 c=0; 101 s=1; 110 s=0; 111 v=1.
REQ-014 flags_q SHALL load {carryflag,signflag,overflowflag,zflag} on an edge where flag_we=1 and state=IDLE; otherwise hold.
REQ-015 flag_we SHALL be ignored while state is REDIRECT or FLUSH (squashed instructions).
REQ-016 FSM states IDLE, REDIRECT, FLUSH; IDLE->REDIRECT on edge with br_valid=1 and condition true; REDIRECT->FLUSH unconditionally; FLUSH->IDLE unconditionally.
REQ-017 Not-taken branch SHALL leave state in IDLE and produce no output pulse.
REQ-018 taken SHALL be 1 for exactly the one cycle in REDIRECT; redirect_pc SHALL equal br_target captured at the evaluating edge and hold until next taken branch.
REQ-019 flush SHALL be 1 in REDIRECT and FLUSH (two-cycle squash), 0 in IDLE.
REQ-020 busy SHALL be 1 whenever state != IDLE.
REQ-021 br_valid SHALL be ignored while state != IDLE.
REQ-022 link_we SHALL pulse together with taken when link_en was 1 at the evaluating edge; link_value SHALL equal pc_plus captured then, held otherwise.
REQ-023 link_en on a not-taken branch SHALL produce no link_we.
REQ-024 Latency: br_valid at edge N -> taken/flush visible after edge N; flush deasserts after edge N+2.

Reset
REQ-025 On rst=1 at an edge: state IDLE; flags_q, redirect_pc, link_value = 0; taken, flush, busy, link_we = 0.
REQ-026 rst SHALL take priority over every input, including mid-REDIRECT/FLUSH; no pending taken or link_we survives reset.

Configuration
REQ-027 Macro FLAG_BYPASS_EN defined: when flag_we=1 and br_valid=1 at the same IDLE edge, condition SHALL use incoming ALU flags.
REQ-028 FLAG_BYPASS_EN undefined: condition SHALL always use flags_q (previous value); incoming flags still captured per REQ-014.

Verification
REQ-029 Reset then flag_we=1 with z=1; next cycle br_valid=1, br_cond=001, br_target=0x40 -> taken=1 one cycle, redirect_pc=0x40, flush=1 two cycles, busy=1 two cycles.
REQ-030 flags_q zero=0; br_cond=001 -> taken, flush, busy stay 0; state IDLE.
REQ-031 Same edge flag_we=1 (z=1, prior z=0), br_valid=1, br_cond=001: with FLAG_BYPASS_EN -> taken=1; without -> taken=0, flags_q=0001 afterwards.
REQ-032 br_cond=000, link_en=1, pc_plus=0x104, br_target=0x200 -> link_we=1 with taken, link_value=0x104, redirect_pc=0x200.
REQ-033 Taken branch, then br_valid=1 cond 000 target 0x80 and flag_we=1 during REDIRECT -> no second taken, flags_q unchanged.
REQ-034 rst=1 asserted in REDIRECT cycle -> next cycle all outputs 0, busy=0, no further flush.
